// File: rtl/shift_add_mul.sv
// Rebuilds a dividend from a quotient and remainder by a fixed divisor B.
// The multiply is done serially, one shift-and-add step per quotient bit.
module shift_add_mul #(
    parameter int            W = 15,
    parameter logic [W-1:0]  B = W'(16)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     quotient,
    input  logic [W-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product,
    output logic             ovf
);

    // state | meaning
    // IDLE  | waiting for start
    // CALC  | one quotient bit per cycle, counter selects the bit
    // DONE  | result valid for this single cycle; start here chains the next job
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int             CW    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0]  LAST  = CW'(W - 1);
    localparam logic [2*W-1:0] B_EXT = {{W{1'b0}}, B};

    state_t           state, state_nxt;
    logic [W-1:0]     q_lat;
    logic [CW-1:0]    cnt;
    logic [2*W-1:0]   acc, acc_sum;
    logic             load, last;

    assign last    = (cnt == LAST);
    assign acc_sum = acc + (q_lat[cnt] ? (B_EXT << cnt) : '0);
    assign busy    = (state == CALC);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The accumulator starts at the remainder, so it doubles as the remainder latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_lat   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
            ovf     <= 1'b0;
        end else if (load) begin
            q_lat <= quotient;
            acc   <= {{W{1'b0}}, remainder};
            cnt   <= '0;
        end else if (state == CALC) begin
            acc <= acc_sum;
            cnt <= last ? '0 : cnt + 1'b1;
            if (last) begin
                product <= acc_sum;
                ovf     <= |acc_sum[2*W-1:W];
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul: fixed vectors, latency/busy checks,
// chained starts, asynchronous reset abort and a randomized sweep.
module tb_shift_add_mul;
    localparam int W = 15;
    localparam int B = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    quotient = '0;
    logic [W-1:0]    remainder = '0;
    logic            busy, done, ovf;
    logic [2*W-1:0]  product;

    int checks = 0;
    int errors = 0;

    shift_add_mul #(.W(W), .B(W'(B))) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .quotient(quotient),
        .remainder(remainder), .busy(busy), .done(done), .product(product), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint q;
        longint r;
        longint exp_prod;
        bit     exp_ovf;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint ref_prod(input longint q, input longint r);
        return q * B + r;
    endfunction

    // Assumes start/operands are already set up for the coming posedge (edge T).
    task automatic wait_result(input bit churn, output longint prod, output bit ov,
                               output int lat, output int busy_cnt);
        int cycles;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        busy_cnt = 0;
        while (!done && cycles < 100) begin
            if (busy) busy_cnt++;
            if (churn) begin
                quotient  = W'($urandom);
                remainder = W'($urandom);
                start     = (cycles < W - 1) ? 1'($urandom) : 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        if (cycles >= 100) chk("done_timeout", cycles, W);
        prod = product;
        ov   = ovf;
        lat  = cycles;
    endtask

    task automatic run_op(input longint q, input longint r, input bit churn,
                          output longint prod, output bit ov, output int lat,
                          output int busy_cnt);
        @(negedge clk);
        start = 1'b1;
        quotient = W'(q);
        remainder = W'(r);
        wait_result(churn, prod, ov, lat, busy_cnt);
    endtask

    vec_t   vecs[8];
    longint prod, qs[64], rs[64];
    bit     ov;
    int     lat, bcnt;

    initial begin
        vecs[0] = '{100, 5, 1605, 0};
        vecs[1] = '{32767, 32767, 557039, 1};
        vecs[2] = '{0, 0, 0, 0};
        vecs[3] = '{0, 9, 9, 0};
        vecs[4] = '{3, 1, 49, 0};
        vecs[5] = '{1, 0, 16, 0};
        vecs[6] = '{2047, 15, 32767, 0};
        vecs[7] = '{2048, 0, 32768, 1};

        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        chk("reset_ovf", ovf, 0);
        #20 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].q, vecs[i].r, 1'b1, prod, ov, lat, bcnt);
            chk($sformatf("vec%0d_product", i), prod, vecs[i].exp_prod);
            chk($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_ovf);
            chk($sformatf("vec%0d_latency", i), lat, W);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, W);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_done_width", i), done, 0);
            chk($sformatf("vec%0d_idle_busy", i), busy, 0);
        end

        repeat (3) @(posedge clk);
        #1 chk("hold_product", product, 32768);
        chk("hold_ovf", ovf, 1);

        // Start held for 40 cycles: jobs accepted every W+1 edges from the first.
        for (int e = 0; e < 56; e++) begin
            start     = (e < 40);
            quotient  = W'($urandom);
            remainder = W'($urandom);
            qs[e] = quotient;
            rs[e] = remainder;
            @(posedge clk); #1;
            chk($sformatf("chain_done_e%0d", e), done, (e % (W + 1) == W && e < 40 + W));
            if (e % (W + 1) == W && e < 40 + W)
                chk($sformatf("chain_product_e%0d", e), product, ref_prod(qs[e - W], rs[e - W]));
        end

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; quotient = W'(500); remainder = W'(7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        chk("abort_ovf", ovf, 0);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        @(negedge clk);
        start = 1'b1; quotient = W'(3); remainder = W'(1);
        rst_n = 1'b1;
        wait_result(1'b0, prod, ov, lat, bcnt);
        chk("post_reset_product", prod, 49);
        chk("post_reset_ovf", ov, 0);
        chk("post_reset_latency", lat, W);

        for (int i = 0; i < 2000; i++) begin
            longint q, r;
            q = $urandom_range(32767, 0);
            r = $urandom_range(B - 1, 0);
            run_op(q, r, 1'b1, prod, ov, lat, bcnt);
            chk("rand_div", prod / B, q);
            chk("rand_mod", prod % B, r);
            chk("rand_ovf", ov, (ref_prod(q, r) >= (1 << W)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
